// File: rtl/partial_key_loader.sv
`default_nettype none
// ============================================================================
//  Module      : partial_key_loader
//  Description : Serial key-delivery stage for an XOR-locked multiplier
//                netlist. Known key bits and a known/unknown mask arrive
//                MSB-first. On commit, every unknown position is filled
//                (from an internal LFSR when enabled, otherwise with 0).
//                The assembled key is then held stable on keyinput_o.
//                In READY, refill_i redraws only the unknown bits.
//
//  Build macro : PARTIAL_KEY_LFSR_EN
//                defined   -> LFSR fill and refill_i functional
//                undefined -> unknown bits are 0, refill_i ignored
//
//  Ports       : clk, rst            clock, synchronous active-high reset
//                shift_valid_i       qualifies key_bit_i / mask_bit_i
//                key_bit_i           serial key bit (MSB-first)
//                mask_bit_i          1 = known bit, 0 = fill
//                commit_i            assemble the key from the shadows
//                refill_i            redraw unknown bits while READY
//                keyinput_o          key to the locked netlist
//                key_ready_o         keyinput_o valid and stable
//                busy_o              high in SHIFT or FILL
//                error_o             sticky protocol error
//                known_cnt_o         number of known bits in committed key
//
//  Revision    : 1.0 - initial release
// ============================================================================
module partial_key_loader #(
    parameter int                KEY_W     = 64,
    parameter logic [KEY_W-1:0]  LFSR_SEED = 64'hACE1_5EED_1234_9876,
    parameter logic [KEY_W-1:0]  LFSR_POLY = 64'hD800_0000_0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_valid_i,
    input  logic              key_bit_i,
    input  logic              mask_bit_i,
    input  logic              commit_i,
    input  logic              refill_i,
    output logic [KEY_W-1:0]  keyinput_o,
    output logic              key_ready_o,
    output logic              busy_o,
    output logic              error_o,
    output logic [6:0]        known_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FILL  = 2'd2,
        S_READY = 2'd3
    } state_t;

    localparam logic [6:0] c_full_cnt = 7'(KEY_W);

    state_t            r_state, w_state_nxt;
    logic [KEY_W-1:0]  r_shadow_key, w_shadow_key_nxt;
    logic [KEY_W-1:0]  r_shadow_mask, w_shadow_mask_nxt;
    logic [6:0]        r_cnt, w_cnt_nxt;
    logic [KEY_W-1:0]  r_key, w_key_nxt;
    logic              r_key_ready, w_key_ready_nxt;
    logic              r_error, w_error_nxt;
    logic [6:0]        r_known_cnt, w_known_cnt_nxt;
    logic              w_accept;
    logic              w_lfsr_adv;
    logic              w_refill_req;
    logic [KEY_W-1:0]  w_fill_word;

    function automatic logic [6:0] popcount(input logic [KEY_W-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < KEY_W; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

`ifdef PARTIAL_KEY_LFSR_EN
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [KEY_W-1:0] c_lfsr_init =
        (LFSR_SEED == '0) ? KEY_W'(1) : LFSR_SEED;

    logic [KEY_W-1:0] r_lfsr;

    assign w_fill_word  = r_lfsr;
    assign w_refill_req = refill_i;

    // Galois right-shift LFSR; only steps on FILL and on an accepted refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= c_lfsr_init;
        end else if (w_lfsr_adv) begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : '0);
        end
    end
`else
    assign w_fill_word  = '0;
    assign w_refill_req = 1'b0;

    logic w_unused_cfg;
    assign w_unused_cfg = ^{LFSR_SEED, LFSR_POLY, refill_i, w_lfsr_adv};
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_key_nxt         = r_key;
        w_key_ready_nxt   = 1'b0;
        w_error_nxt       = r_error;
        w_known_cnt_nxt   = r_known_cnt;
        w_accept          = 1'b0;
        w_lfsr_adv        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (shift_valid_i) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = 7'd1;
                    w_state_nxt = S_SHIFT;
                end
                if (commit_i) begin
                    w_error_nxt = 1'b1;
                end
            end
            S_SHIFT: begin
                // Commit takes priority over a same-cycle shift; the bit is dropped.
                if (commit_i) begin
                    if (r_cnt == c_full_cnt) begin
                        w_state_nxt = S_FILL;
                    end else begin
                        w_error_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else if (shift_valid_i) begin
                    if (r_cnt == c_full_cnt) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        w_accept  = 1'b1;
                        w_cnt_nxt = r_cnt + 7'd1;
                    end
                end
            end
            S_FILL: begin
                w_key_nxt       = (r_shadow_key & r_shadow_mask) |
                                  (w_fill_word & ~r_shadow_mask);
                w_known_cnt_nxt = popcount(r_shadow_mask);
                w_lfsr_adv      = 1'b1;
                w_state_nxt     = S_READY;
            end
            S_READY: begin
                // A new load wins over a same-cycle refill; keyinput_o keeps
                // its old value until the next FILL.
                if (shift_valid_i) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = 7'd1;
                    w_state_nxt = S_SHIFT;
                end else if (w_refill_req) begin
                    w_key_nxt  = (r_key & r_shadow_mask) |
                                 (w_fill_word & ~r_shadow_mask);
                    w_lfsr_adv = 1'b1;
                end else begin
                    w_key_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_shadow_key_nxt  = r_shadow_key;
        w_shadow_mask_nxt = r_shadow_mask;
        if (w_accept) begin
            w_shadow_key_nxt  = {r_shadow_key[KEY_W-2:0], key_bit_i};
            w_shadow_mask_nxt = {r_shadow_mask[KEY_W-2:0], mask_bit_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_shadow_key  <= '0;
            r_shadow_mask <= '0;
            r_cnt         <= '0;
            r_key         <= '0;
            r_key_ready   <= 1'b0;
            r_error       <= 1'b0;
            r_known_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_shadow_key  <= w_shadow_key_nxt;
            r_shadow_mask <= w_shadow_mask_nxt;
            r_cnt         <= w_cnt_nxt;
            r_key         <= w_key_nxt;
            r_key_ready   <= w_key_ready_nxt;
            r_error       <= w_error_nxt;
            r_known_cnt   <= w_known_cnt_nxt;
        end
    end

    assign keyinput_o  = r_key;
    assign key_ready_o = r_key_ready;
    assign error_o     = r_error;
    assign known_cnt_o = r_known_cnt;
    assign busy_o      = (r_state == S_SHIFT) || (r_state == S_FILL);

endmodule
`default_nettype wire

// File: tb/tb_partial_key_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_partial_key_loader
//  Description : Self-checking bench for partial_key_loader. A behavioural
//                model assembles expected keys bit by bit from the loaded
//                key/mask and a software LFSR, honouring the
//                PARTIAL_KEY_LFSR_EN build macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_partial_key_loader;

    localparam int          KW   = 64;
    localparam logic [63:0] SEED = 64'hACE1_5EED_1234_9876;
    localparam logic [63:0] POLY = 64'hD800_0000_0000_0000;
`ifdef PARTIAL_KEY_LFSR_EN
    localparam bit LFSR_ON = 1'b1;
`else
    localparam bit LFSR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          shift_valid_i, key_bit_i, mask_bit_i, commit_i, refill_i;
    logic [KW-1:0] keyinput_o;
    logic          key_ready_o, busy_o, error_o;
    logic [6:0]    known_cnt_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [63:0] m_lfsr;
    logic [63:0] m_key;
    logic [63:0] m_mask;
    int          m_cnt;

    always #5 clk = ~clk;

    partial_key_loader #(
        .KEY_W     (KW),
        .LFSR_SEED (SEED),
        .LFSR_POLY (POLY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .shift_valid_i (shift_valid_i),
        .key_bit_i     (key_bit_i),
        .mask_bit_i    (mask_bit_i),
        .commit_i      (commit_i),
        .refill_i      (refill_i),
        .keyinput_o    (keyinput_o),
        .key_ready_o   (key_ready_o),
        .busy_o        (busy_o),
        .error_o       (error_o),
        .known_cnt_o   (known_cnt_o)
    );

    // ---------------- model helpers ----------------
    function automatic logic [63:0] lfsr_next(input logic [63:0] v);
        return (v >> 1) ^ (v[0] ? POLY : 64'd0);
    endfunction

    function automatic logic [63:0] fill_source();
        return LFSR_ON ? m_lfsr : 64'd0;
    endfunction

    // Bit-by-bit: a known position takes the supplied bit, an unknown one
    // takes the fill word's bit.
    function automatic logic [63:0] merge(input logic [63:0] known,
                                          input logic [63:0] mask,
                                          input logic [63:0] fill);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = mask[i] ? known[i] : fill[i];
        return r;
    endfunction

    function automatic int count_known(input logic [63:0] mask);
        int n = 0;
        for (int i = 0; i < 64; i++) if (mask[i]) n++;
        return n;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Model of a successful commit (FILL) and of a refill.
    task automatic model_fill(input logic [63:0] k, input logic [63:0] m);
        m_key  = merge(k, m, fill_source());
        m_mask = m;
        m_cnt  = count_known(m);
        if (LFSR_ON) m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic model_refill();
        m_key = merge(m_key, m_mask, fill_source());
        if (LFSR_ON) m_lfsr = lfsr_next(m_lfsr);
    endtask

    // ---------------- stimulus helpers (no checks) ----------------
    task automatic do_reset();
        rst = 1'b1;
        shift_valid_i = 0; key_bit_i = 0; mask_bit_i = 0;
        commit_i = 0; refill_i = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_lfsr = (SEED == 64'd0) ? 64'd1 : SEED;
    endtask

    // Drive n bits starting at MSB-first position 'start'.
    task automatic shift_bits(input logic [63:0] k, input logic [63:0] m,
                              input int start, input int n);
        for (int i = start; i < start + n; i++) begin
            shift_valid_i = 1'b1;
            key_bit_i     = k[63-i];
            mask_bit_i    = m[63-i];
            @(negedge clk);
        end
        shift_valid_i = 1'b0;
        key_bit_i     = 1'b0;
        mask_bit_i    = 1'b0;
    endtask

    // Pulse commit and count negedges until key_ready_o rises (bounded).
    task automatic commit_wait(output int lat);
        commit_i = 1'b1;
        lat = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            commit_i = 1'b0;
            lat++;
            if (key_ready_o === 1'b1) break;
        end
    endtask

    task automatic pulse_refill();
        refill_i = 1'b1;
        @(negedge clk);
        refill_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++; if (keyinput_o !== 64'd0) begin bad++; $display("FAIL reset_key got=%h exp=0", keyinput_o); end
        total++; if (key_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", key_ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (error_o !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", error_o); end
        total++; if (known_cnt_o !== 7'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", known_cnt_o); end
    endtask

    task automatic test_known_key();
        logic [63:0] k = 64'hFFFF_0000_1234_5678;
        logic [63:0] m = '1;
        int lat;
        shift_bits(k, m, 0, 32);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL known_busy got=%b exp=1", busy_o); end
        shift_bits(k, m, 32, 32);
        commit_wait(lat);
        model_fill(k, m);
        total++; if (lat !== 3) begin bad++; $display("FAIL known_latency got=%0d exp=3", lat); end
        total++; if (keyinput_o !== 64'hFFFF_0000_1234_5678) begin bad++; $display("FAIL known_key got=%h exp=%h", keyinput_o, 64'hFFFF_0000_1234_5678); end
        total++; if (known_cnt_o !== 7'd64) begin bad++; $display("FAIL known_cnt got=%0d exp=64", known_cnt_o); end
        total++; if (error_o !== 1'b0) begin bad++; $display("FAIL known_error got=%b exp=0", error_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL known_busy_ready got=%b exp=0", busy_o); end
    endtask

    task automatic test_lfsr_fill();
        logic [63:0] k = rand64();
        int lat;
        do_reset();
        shift_bits(k, 64'd0, 0, 64);
        commit_wait(lat);
        model_fill(k, 64'd0);
        total++; if (keyinput_o !== m_key) begin bad++; $display("FAIL fill_key got=%h exp=%h", keyinput_o, m_key); end
        total++; if (known_cnt_o !== 7'd0) begin bad++; $display("FAIL fill_cnt got=%0d exp=0", known_cnt_o); end
        pulse_refill();
        model_refill();
        total++; if (key_ready_o !== !LFSR_ON) begin bad++; $display("FAIL refill_ready_low got=%b exp=%b", key_ready_o, !LFSR_ON); end
        total++; if (keyinput_o !== m_key) begin bad++; $display("FAIL refill_key got=%h exp=%h", keyinput_o, m_key); end
        @(negedge clk);
        total++; if (key_ready_o !== 1'b1) begin bad++; $display("FAIL refill_ready_back got=%b exp=1", key_ready_o); end
    endtask

    task automatic test_half_mask();
        logic [63:0] k = 64'hDEAD_BEEF_CAFE_F00D;
        logic [63:0] m = 64'h0000_0000_FFFF_FFFF;
        int lat;
        shift_bits(k, m, 0, 64);
        commit_wait(lat);
        model_fill(k, m);
        total++; if (known_cnt_o !== 7'd32) begin bad++; $display("FAIL half_cnt got=%0d exp=32", known_cnt_o); end
        total++; if (keyinput_o !== m_key) begin bad++; $display("FAIL half_key got=%h exp=%h", keyinput_o, m_key); end
        for (int r = 0; r < 3; r++) begin
            pulse_refill();
            model_refill();
            @(negedge clk);
            total++; if (keyinput_o[31:0] !== 32'hCAFE_F00D) begin bad++; $display("FAIL half_low%0d got=%h exp=cafef00d", r, keyinput_o[31:0]); end
            total++; if (keyinput_o !== m_key) begin bad++; $display("FAIL half_refill%0d got=%h exp=%h", r, keyinput_o, m_key); end
        end
    endtask

    task automatic test_random();
        int lat;
        for (int t = 0; t < 5; t++) begin
            logic [63:0] k = rand64();
            logic [63:0] m = rand64();
            int nref = $urandom_range(0, 2);
            shift_bits(k, m, 0, 64);
            commit_wait(lat);
            model_fill(k, m);
            total++; if (lat !== 3) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=3", t, lat); end
            total++; if (keyinput_o !== m_key) begin bad++; $display("FAIL rand%0d_key got=%h exp=%h", t, keyinput_o, m_key); end
            total++; if (known_cnt_o !== 7'(m_cnt)) begin bad++; $display("FAIL rand%0d_cnt got=%0d exp=%0d", t, known_cnt_o, m_cnt); end
            for (int r = 0; r < nref; r++) begin
                pulse_refill();
                model_refill();
                @(negedge clk);
                total++; if (keyinput_o !== m_key) begin bad++; $display("FAIL rand%0d_refill%0d got=%h exp=%h", t, r, keyinput_o, m_key); end
            end
        end
        // commit while READY is ignored
        commit_i = 1'b1;
        @(negedge clk);
        commit_i = 1'b0;
        @(negedge clk);
        total++; if (error_o !== 1'b0) begin bad++; $display("FAIL ready_commit_error got=%b exp=0", error_o); end
        total++; if (key_ready_o !== 1'b1) begin bad++; $display("FAIL ready_commit_ready got=%b exp=1", key_ready_o); end
        total++; if (keyinput_o !== m_key) begin bad++; $display("FAIL ready_commit_key got=%h exp=%h", keyinput_o, m_key); end
    endtask

    task automatic test_early_commit();
        logic [63:0] k = rand64();
        logic [63:0] m = rand64();
        int lat;
        shift_bits(k, m, 0, 10);
        commit_i = 1'b1;
        @(negedge clk);
        commit_i = 1'b0;
        total++; if (error_o !== 1'b1) begin bad++; $display("FAIL early_error got=%b exp=1", error_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL early_busy got=%b exp=0", busy_o); end
        total++; if (key_ready_o !== 1'b0) begin bad++; $display("FAIL early_ready got=%b exp=0", key_ready_o); end
        k = rand64();
        m = rand64();
        shift_bits(k, m, 0, 64);
        commit_wait(lat);
        model_fill(k, m);
        total++; if (lat !== 3) begin bad++; $display("FAIL early_reload_latency got=%0d exp=3", lat); end
        total++; if (keyinput_o !== m_key) begin bad++; $display("FAIL early_reload_key got=%h exp=%h", keyinput_o, m_key); end
        total++; if (error_o !== 1'b1) begin bad++; $display("FAIL early_sticky got=%b exp=1", error_o); end
    endtask

    task automatic test_overflow();
        logic [63:0] k = rand64();
        logic [63:0] m = rand64();
        int lat;
        do_reset();
        shift_bits(k, m, 0, 64);
        shift_valid_i = 1'b1; key_bit_i = ~k[0]; mask_bit_i = 1'b1;
        @(negedge clk);
        shift_valid_i = 1'b0;
        total++; if (error_o !== 1'b1) begin bad++; $display("FAIL overflow_error got=%b exp=1", error_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL overflow_busy got=%b exp=1", busy_o); end
        commit_wait(lat);
        model_fill(k, m);
        total++; if (keyinput_o !== m_key) begin bad++; $display("FAIL overflow_key got=%h exp=%h", keyinput_o, m_key); end
    endtask

    task automatic test_reset_mid_load();
        logic [63:0] k = rand64();
        logic [63:0] m = rand64();
        int lat;
        shift_bits(k, m, 0, 40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = (SEED == 64'd0) ? 64'd1 : SEED;
        total++; if (keyinput_o !== 64'd0) begin bad++; $display("FAIL midrst_key got=%h exp=0", keyinput_o); end
        total++; if (error_o !== 1'b0) begin bad++; $display("FAIL midrst_error got=%b exp=0", error_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
        total++; if (known_cnt_o !== 7'd0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", known_cnt_o); end
        k = rand64();
        m = rand64();
        shift_bits(k, m, 0, 64);
        commit_wait(lat);
        model_fill(k, m);
        total++; if (keyinput_o !== m_key) begin bad++; $display("FAIL midrst_reload_key got=%h exp=%h", keyinput_o, m_key); end
        total++; if (known_cnt_o !== 7'(m_cnt)) begin bad++; $display("FAIL midrst_reload_cnt got=%0d exp=%0d", known_cnt_o, m_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] k = rand64();
        logic [63:0] m = rand64();
        logic [63:0] old_key = m_key;
        shift_bits(k, m, 0, 20);
        total++; if (key_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_ready got=%b exp=0", key_ready_o); end
        total++; if (keyinput_o !== old_key) begin bad++; $display("FAIL b2b_hold got=%h exp=%h", keyinput_o, old_key); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy_o); end
        shift_bits(k, m, 20, 44);
        // commit together with a shift: commit wins, bit dropped, no error
        commit_i = 1'b1; shift_valid_i = 1'b1; key_bit_i = ~k[0]; mask_bit_i = 1'b1;
        @(negedge clk);
        commit_i = 1'b0; shift_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        model_fill(k, m);
        total++; if (key_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_commit_ready got=%b exp=1", key_ready_o); end
        total++; if (keyinput_o !== m_key) begin bad++; $display("FAIL b2b_key got=%h exp=%h", keyinput_o, m_key); end
        total++; if (error_o !== 1'b0) begin bad++; $display("FAIL b2b_error got=%b exp=0", error_o); end
    endtask

    initial begin
        test_reset();
        test_known_key();
        test_lfsr_fill();
        test_half_mask();
        test_random();
        test_early_commit();
        test_overflow();
        test_reset_mid_load();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
